// File: rtl/m72_pkg.sv
// Shared types for the SDRAM channel 3 arbiter: requester ids, FSM states
// and the latched downstream command.
package m72_pkg;

  typedef enum logic [1:0] {SRC_NONE, SRC_ROM, SRC_CPU, SRC_AUX} arb_src_t;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} arb_state_t;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] din;
    logic [1:0]  be;
    logic        rnw;
  } arb_cmd_t;

  localparam arb_cmd_t CMD_RESET = '{addr: 24'h0, din: 16'h0, be: 2'b00, rnw: 1'b1};

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

endpackage

// File: rtl/sdr_arb_pick.sv
// Combinational winner selection: ROM > CPU > aux, aux promoted over CPU
// when starving; CPU and aux are locked out during ROM download.
module sdr_arb_pick
  import m72_pkg::*;
(
  input  logic     rom_req,
  input  logic     cpu_req,
  input  logic     aux_req,
  input  logic     dl_active,
  input  logic     promote,
  output arb_src_t src
);

  always_comb begin
    src = SRC_NONE;
    if (rom_req) src = SRC_ROM;
    else if (!dl_active) begin
      if (promote && aux_req) src = SRC_AUX;
      else if (cpu_req)       src = SRC_CPU;
      else if (aux_req)       src = SRC_AUX;
    end
  end

endmodule

// File: rtl/sdr_ch3_arbiter.sv
// Sequential arbiter sharing SDRAM channel 3 between ROM loader, CPU and an
// aux port; one downstream transaction in flight at a time.
module sdr_ch3_arbiter
  import m72_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dl_active,

  input  logic        rom_req,
  input  logic [23:0] rom_addr,
  input  logic [15:0] rom_din,
  input  logic [1:0]  rom_be,
  output logic        rom_rdy,

  input  logic        cpu_req,
  input  logic [23:0] cpu_addr,
  input  logic [15:0] cpu_din,
  input  logic [1:0]  cpu_be,
  input  logic        cpu_rnw,
  output logic [15:0] cpu_dout,
  output logic        cpu_rdy,

  input  logic        aux_req,
  input  logic [23:0] aux_addr,
  input  logic [15:0] aux_din,
  input  logic [1:0]  aux_be,
  input  logic        aux_rnw,
  output logic [15:0] aux_dout,
  output logic        aux_rdy,

  output logic [23:0] ch3_addr,
  output logic [15:0] ch3_din,
  output logic [1:0]  ch3_be,
  output logic        ch3_rnw,
  output logic        ch3_req,
  input  logic [15:0] ch3_dout,
  input  logic        ch3_ready,

  output logic        busy,
  output arb_src_t    grant
);

  arb_state_t state, state_nxt;
  arb_src_t   win;
  arb_cmd_t   cmd, win_cmd;
  logic [7:0] starve_cnt;
  logic       promote;

  assign promote = (starve_cnt == 8'(STARVE_LIMIT));

  sdr_arb_pick u_pick (
    .rom_req   (rom_req),
    .cpu_req   (cpu_req),
    .aux_req   (aux_req),
    .dl_active (dl_active),
    .promote   (promote),
    .src       (win)
  );

  // ROM loader only ever writes, so its rnw is forced low here.
  always_comb begin
    win_cmd = CMD_RESET;
    case (win)
      SRC_ROM: win_cmd = '{rom_addr, rom_din, rom_be, 1'b0};
      SRC_CPU: win_cmd = '{cpu_addr, cpu_din, cpu_be, cpu_rnw};
      SRC_AUX: win_cmd = '{aux_addr, aux_din, aux_be, aux_rnw};
      default: win_cmd = CMD_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (win != SRC_NONE) state_nxt = ST_WAIT;
      ST_WAIT: if (ch3_ready)       state_nxt = ST_DONE;
      ST_DONE:                      state_nxt = ST_IDLE;
      default:                      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != ST_IDLE);
    rom_rdy = (state == ST_DONE) && (grant == SRC_ROM);
    cpu_rdy = (state == ST_DONE) && (grant == SRC_CPU);
    aux_rdy = (state == ST_DONE) && (grant == SRC_AUX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd        <= CMD_RESET;
      ch3_req    <= 1'b0;
      grant      <= SRC_NONE;
      starve_cnt <= 8'd0;
      cpu_dout   <= 16'h0;
      aux_dout   <= 16'h0;
    end else begin
      ch3_req <= 1'b0;
      case (state)
        ST_IDLE: if (win != SRC_NONE) begin
          cmd     <= win_cmd;
          grant   <= win;
          ch3_req <= 1'b1;
          // Count CPU wins only while aux is actually waiting.
          if (win == SRC_CPU)
            starve_cnt <= aux_req ? sat_inc(starve_cnt, 8'(STARVE_LIMIT)) : 8'd0;
          else if (win == SRC_AUX)
            starve_cnt <= 8'd0;
        end
        ST_WAIT: if (ch3_ready && cmd.rnw) begin
          if (grant == SRC_CPU) cpu_dout <= ch3_dout;
          if (grant == SRC_AUX) aux_dout <= ch3_dout;
        end
        ST_DONE: grant <= SRC_NONE;
        default: ;
      endcase
    end
  end

  assign ch3_addr = cmd.addr;
  assign ch3_din  = cmd.din;
  assign ch3_be   = cmd.be;
  assign ch3_rnw  = cmd.rnw;

endmodule

// File: doc/sdr_ch3_arbiter.md
# sdr_ch3_arbiter

Sequential arbiter that shares SDRAM channel 3 between three requesters: ROM loader writes, CPU reads/writes and an auxiliary port (hiscore/NVRAM save-restore). It replaces the combinational download/CPU mux in front of `sdram` and runs in the SDRAM clock domain (96 MHz). It issues one downstream transaction at a time, routes the returned data and ready to the owning requester, blocks CPU/aux during ROM download, and guarantees aux forward progress under sustained CPU traffic.

## Interface
- `STARVE_LIMIT`, 8: consecutive CPU grants with aux pending before aux is promoted above CPU (1..255).
- `clk` in 1: SDRAM clock; sole clock.
- `reset` in 1: synchronous, active-high.
- `dl_active` in 1: ROM download in progress; blocks CPU and aux grants.
- `rom_req` in 1; `rom_addr` in 24 [24:1]; `rom_din` in 16; `rom_be` in 2: ROM write request (always a write).
- `rom_rdy` out 1: one-cycle completion pulse.
- `cpu_req` in 1; `cpu_addr` in 24; `cpu_din` in 16; `cpu_be` in 2; `cpu_rnw` in 1: CPU request.
- `cpu_dout` out 16; `cpu_rdy` out 1: read data, completion pulse.
- `aux_req`, `aux_addr`, `aux_din`, `aux_be`, `aux_rnw`, `aux_dout`, `aux_rdy`: same as CPU port.
- `ch3_addr` out 24; `ch3_din` out 16; `ch3_be` out 2; `ch3_rnw` out 1; `ch3_req` out 1: downstream command; `ch3_req` is a one-cycle pulse.
- `ch3_dout` in 16; `ch3_ready` in 1: downstream data, one-cycle completion pulse.
- `busy` out 1: high in any state other than IDLE.
- `grant` out 2: current owner, `arb_src_t`.

## Operation
- Requester protocol: `*_req` is a level, held with stable addr/din/be/rnw until the matching `*_rdy` pulse; requester drops or changes the request in the cycle after `*_rdy`.
- States: IDLE, WAIT, DONE.
- IDLE: pick winner from eligible requests; if one exists, latch its command into the `ch3_*` registers, set `grant`, pulse `ch3_req` next cycle, go to WAIT. Otherwise stay; `ch3_ready` is ignored.
- Eligibility: ROM always; CPU and aux only when `dl_active`=0.
- Priority: ROM > CPU > aux; when the starvation counter equals `STARVE_LIMIT` and aux is eligible: ROM > aux > CPU.
- Starvation counter (8-bit): on a CPU grant with `aux_req` high, increment (saturating at `STARVE_LIMIT`); cleared on an aux grant, or on a CPU grant with `aux_req` low.
- ROM grants force `ch3_rnw`=0, regardless of inputs.
- WAIT: on `ch3_ready`=1 (any WAIT cycle, including the `ch3_req` cycle), capture `ch3_dout` into the owner's dout register, pulse the owner's rdy next cycle, go to DONE.
- DONE: one cycle, rdy high; no arbitration. Next cycle IDLE, `grant`=SRC_NONE.
- `dl_active` rising during a CPU/aux transaction: that transaction completes normally; blocking applies from the next IDLE.
- Non-owner dout registers hold their last value. Writes leave the owner's dout unchanged.

## Timing
- Reset values: `ch3_req`=0, `ch3_addr`=0, `ch3_din`=0, `ch3_be`=0, `ch3_rnw`=1, all `*_rdy`=0, all `*_dout`=0, `busy`=0, `grant`=SRC_NONE, counter=0, state IDLE.
- Reset mid-transaction: return to IDLE at once; pending `*_rdy` is not issued; a late `ch3_ready` is ignored.
- Request sampled at T (IDLE): `ch3_req`=1 at T+1 only; `ch3_*` command stable from T+1 until leaving DONE.
- `ch3_ready` at cycle R: `*_rdy`=1 and dout valid at R+1 (DONE); IDLE at R+2; earliest next `ch3_req` at R+3.
- Simultaneous requests in IDLE: exactly one grant per priority rule; losers are held, never dropped.

## Structure
- `m72_pkg` gains `typedef enum logic [1:0] {SRC_NONE, SRC_ROM, SRC_CPU, SRC_AUX} arb_src_t` and the state enum `arb_state_t`.
- One natural sub-module: `sdr_arb_pick`, a combinational picker. Inputs are the three reqs, `dl_active` and a promote flag; output is `arb_src_t`.
- Top level instantiates the arbiter in place of the `sdr_ch3_*` mux. It connects `rom_loader`, the `m72` CPU bus and the aux port. `dl_active` = `ioctl_download && ioctl_index==0`.

## Test plan
- ROM write 0x1234 to addr 0x000100, be=11, `ch3_ready` 5 cycles after `ch3_req` -> `ch3_rnw`=0, `rom_rdy` one cycle after `ch3_ready`, `grant`=SRC_ROM during the transaction.
- CPU read and ROM write asserted in the same cycle, `dl_active`=1 -> ROM served first; CPU not granted until `dl_active`=0; then `cpu_dout` = returned 0xBEEF.
- CPU back-to-back reads with `aux_req` held, `STARVE_LIMIT`=8 -> 8 CPU grants, then aux granted, then counter=0 and CPU resumes.
- `ch3_ready` in the same cycle as `ch3_req` -> `cpu_rdy` at the next cycle, DONE for 1 cycle, IDLE after.
- `reset` pulsed in WAIT, then `ch3_ready` arrives -> all outputs at reset values, no `*_rdy` pulse, `busy`=0.
- Aux write of 0xA5A5 with be=01 -> `ch3_be`=01, `ch3_rnw`=0, `aux_dout` unchanged, `aux_rdy` single pulse.
